// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register decode,
// STATUS bit layout and transmit state encoding.
package uart_pkg;

  // Register select codes are the byte offset bits [3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;  // offset 0x0
  localparam logic [1:0] REG_STATUS  = 2'd1;  // offset 0x4
  localparam logic [1:0] REG_BAUDDIV = 2'd2;  // offset 0x8

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } tx_state_e;

  function automatic logic [1:0] reg_sel(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, registered read mux,
// TX FIFO and bit-serialising state machine.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 868,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_Sel_1,
  input  logic        i_WriteEnable_1,
  input  logic [3:0]  i_WriteAddr_4,
  input  logic [31:0] i_WriteData_32,
  input  logic [3:0]  i_ReadAddr_4,
  output logic [31:0] o_ReadData_32,
  output logic        o_Tx_1,
  output logic        o_TxEmptyIrq_1
);

  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_en, push, pop, bit_done;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_data;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      status_word;
  logic             unused_bits;

  assign wr_en = i_Sel_1 && i_WriteEnable_1;
  assign push  = wr_en && (reg_sel(i_WriteAddr_4) == REG_TXDATA);
  assign unused_bits = ^{i_WriteData_32, i_WriteAddr_4[1:0], i_ReadAddr_4[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (i_WriteData_32[7:0]),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_BUSY]  = (state_q != IDLE);
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_OVF]   = ovf_q;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB] = 9'(fifo_count);
  end

  // Register writes; a zero divisor would stall the shifter, so it becomes 1
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_en && (reg_sel(i_WriteAddr_4) == REG_BAUDDIV)) begin
      div_d = (i_WriteData_32[DIV_W-1:0] == '0) ? DIV_W'(1) : i_WriteData_32[DIV_W-1:0];
    end
    if (wr_en && (reg_sel(i_WriteAddr_4) == REG_STATUS) && i_WriteData_32[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (i_Sel_1) begin
      case (reg_sel(i_ReadAddr_4))
        REG_STATUS:  rdata_d = status_word;
        REG_BAUDDIV: rdata_d = 32'(div_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  // Each bit reloads its counter from the live divisor, so divisor writes land on the next bit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    bit_done = (cnt_q == '0);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          cnt_d   = div_q - 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = div_q - 1'b1;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = div_q - 1'b1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = fifo_empty && (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(DEFAULT_DIV);
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_Tx_1         = tx_q;
  assign o_TxEmptyIrq_1 = irq_q;
  assign o_ReadData_32  = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: line samples are captured every cycle and
// compared against an ideal 8N1 waveform built from the bytes written.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_Sel_1 = 1'b0;
  logic        i_WriteEnable_1 = 1'b0;
  logic [3:0]  i_WriteAddr_4 = '0;
  logic [31:0] i_WriteData_32 = '0;
  logic [3:0]  i_ReadAddr_4 = '0;
  logic [31:0] o_ReadData_32;
  logic        o_Tx_1;
  logic        o_TxEmptyIrq_1;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  typedef struct packed {
    logic tx;
    logic irq;
    logic busy;
  } sample_t;

  sample_t    capQ[$];
  bit         capOn = 1'b0;
  logic [7:0] expBytes[$];
  int         expDurs[$];

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_Sel_1         (i_Sel_1),
    .i_WriteEnable_1 (i_WriteEnable_1),
    .i_WriteAddr_4   (i_WriteAddr_4),
    .i_WriteData_32  (i_WriteData_32),
    .i_ReadAddr_4    (i_ReadAddr_4),
    .o_ReadData_32   (o_ReadData_32),
    .o_Tx_1          (o_Tx_1),
    .o_TxEmptyIrq_1  (o_TxEmptyIrq_1)
  );

  always begin
    @(negedge clk);
    #1;
    if (capOn) capQ.push_back({o_Tx_1, o_TxEmptyIrq_1, o_ReadData_32[0]});
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    i_Sel_1         = 1'b1;
    i_WriteEnable_1 = 1'b1;
    i_WriteAddr_4   = addr;
    i_WriteData_32  = data;
    @(negedge clk);
    i_Sel_1         = 1'b0;
    i_WriteEnable_1 = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
    i_Sel_1         = 1'b1;
    i_WriteEnable_1 = 1'b0;
    i_ReadAddr_4    = addr;
    @(negedge clk);
    data    = o_ReadData_32;
    i_Sel_1 = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] val;
    readReg(addr, val);
    checkOutput(tag, val, exp);
  endtask

  task automatic waitIdle(input string tag, input int bound);
    int n = 0;
    repeat (2) @(negedge clk);
    while (!o_TxEmptyIrq_1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(o_TxEmptyIrq_1), 32'd1);
  endtask

  // Ideal waveform: per byte a start bit, 8 data bits LSB first and a stop bit,
  // with one idle-high cycle between consecutive frames
  task automatic checkCapture(input string tag, input bit chkBusy, output int s);
    logic       expW[$];
    logic [7:0] b, rx;
    int         len, errs, irqErrs, busyErrs, tailErrs, pos, mid, idx;
    for (int j = 0; j < expBytes.size(); j++) begin
      b = expBytes[j];
      if (j > 0) expW.push_back(1'b1);
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < expDurs[j*10+k]; c++) begin
          if (k == 0)      expW.push_back(1'b0);
          else if (k == 9) expW.push_back(1'b1);
          else             expW.push_back(b[k-1]);
        end
      end
    end
    len = expW.size();
    s = -1;
    for (int i = 0; i < capQ.size(); i++) begin
      if (capQ[i].tx == 1'b0) begin
        s = i;
        break;
      end
    end
    checkOutput({tag, "_start"}, 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    errs = 0; irqErrs = 0; busyErrs = 0; tailErrs = 0;
    for (int i = 0; i < len; i++) begin
      idx = s + i;
      if (idx >= capQ.size()) begin
        errs++;
      end else begin
        if (capQ[idx].tx !== expW[i]) errs++;
        if (capQ[idx].irq !== 1'b0) irqErrs++;
        if (i > 0 && capQ[idx].busy !== 1'b1) busyErrs++;
      end
    end
    for (int i = s + len; i < capQ.size(); i++) begin
      if (capQ[i].tx !== 1'b1) tailErrs++;
    end
    checkOutput({tag, "_wave"}, 32'(errs), 32'd0);
    checkOutput({tag, "_irq_low"}, 32'(irqErrs), 32'd0);
    if (chkBusy) checkOutput({tag, "_busy"}, 32'(busyErrs), 32'd0);
    checkOutput({tag, "_tail"}, 32'(tailErrs), 32'd0);
    if (capQ.size() > 0) checkOutput({tag, "_irq_end"}, 32'(capQ[capQ.size()-1].irq), 32'd1);
    pos = s;
    for (int j = 0; j < expBytes.size(); j++) begin
      if (j > 0) pos++;
      pos += expDurs[j*10];
      for (int k = 0; k < 8; k++) begin
        mid = pos + expDurs[j*10+1+k] / 2;
        rx[k] = (mid < capQ.size()) ? capQ[mid].tx : 1'bx;
        pos += expDurs[j*10+1+k];
      end
      pos += expDurs[j*10+9];
      checkOutput($sformatf("%s_byte%0d", tag, j), 32'(rx), 32'(expBytes[j]));
    end
  endtask

  task automatic setDurs(input int d);
    expDurs.delete();
    for (int j = 0; j < expBytes.size(); j++) begin
      repeat (10) expDurs.push_back(d);
    end
  endtask

  initial begin
    int          s, n, div, nb, zeros;
    logic [7:0]  b;
    logic [31:0] dummy;

    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(o_Tx_1), 32'd1);
    checkOutput("rst_irq", 32'(o_TxEmptyIrq_1), 32'd1);
    checkOutput("rst_rdata", o_ReadData_32, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkReg("status_reset", 4'h4, 32'h4);
    checkReg("baud_reset", 4'h8, 32'd868);
    checkReg("txdata_read", 4'h0, 32'd0);
    checkReg("reserved_read", 4'hC, 32'd0);

    $display("[TB] single frame 0xA5 at divisor 4");
    applyStimulus(4'h8, 32'd4);
    checkReg("baud_wr4", 4'h8, 32'd4);
    capQ.delete();
    applyStimulus(4'h0, 32'hA5);
    capOn = 1'b1;
    i_Sel_1 = 1'b1;
    i_ReadAddr_4 = 4'h4;
    waitIdle("a5", 200);
    repeat (3) @(negedge clk);
    capOn = 1'b0;
    i_Sel_1 = 1'b0;
    expBytes = '{8'hA5};
    setDurs(4);
    checkCapture("a5", 1'b1, s);
    checkOutput("a5_latency", 32'(s), 32'd1);

    $display("[TB] overflow with divisor 2");
    applyStimulus(4'h8, 32'd2);
    for (int i = 0; i < 17; i++) applyStimulus(4'h0, 32'($urandom_range(0, 255)));
    checkReg("ovf_full_no_ovf", 4'h4, 32'h103);
    applyStimulus(4'h0, 32'h5A);
    checkReg("ovf_set", 4'h4, 32'h10B);
    applyStimulus(4'h4, 32'h8);
    checkReg("ovf_cleared", 4'h4, 32'h103);
    waitIdle("ovf_drain", 1500);
    repeat (2) @(negedge clk);
    checkReg("ovf_drained", 4'h4, 32'h4);

    $display("[TB] back-to-back frames at divisor 1");
    applyStimulus(4'h8, 32'd1);
    capQ.delete();
    capOn = 1'b1;
    expBytes.delete();
    for (int j = 0; j < 2; j++) begin
      b = 8'($urandom_range(0, 255));
      expBytes.push_back(b);
      applyStimulus(4'h0, 32'(b));
    end
    waitIdle("b2b", 200);
    repeat (3) @(negedge clk);
    capOn = 1'b0;
    setDurs(1);
    checkCapture("b2b", 1'b0, s);

    $display("[TB] zero divisor and mid-frame divisor change");
    applyStimulus(4'h8, 32'd0);
    checkReg("baud_zero", 4'h8, 32'd1);
    applyStimulus(4'h8, 32'd3);
    capQ.delete();
    capOn = 1'b1;
    applyStimulus(4'h0, 32'h3C);
    n = 0;
    while (o_Tx_1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    applyStimulus(4'h8, 32'd6);
    waitIdle("divchg", 300);
    repeat (3) @(negedge clk);
    capOn = 1'b0;
    expBytes = '{8'h3C};
    expDurs = '{3, 3, 6, 6, 6, 6, 6, 6, 6, 6};
    checkCapture("divchg", 1'b0, s);
    checkReg("baud_six", 4'h8, 32'd6);

    $display("[TB] randomized bursts");
    for (int t = 0; t < 5; t++) begin
      div = $urandom_range(1, 4);
      nb  = $urandom_range(1, 4);
      applyStimulus(4'h8, 32'(div));
      capQ.delete();
      capOn = 1'b1;
      expBytes.delete();
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom_range(0, 255));
        expBytes.push_back(b);
        applyStimulus(4'h0, 32'(b));
      end
      waitIdle($sformatf("rnd%0d", t), 400);
      repeat (3) @(negedge clk);
      capOn = 1'b0;
      setDurs(div);
      checkCapture($sformatf("rnd%0d", t), 1'b0, s);
    end

    $display("[TB] reset during a frame");
    applyStimulus(4'h8, 32'd4);
    applyStimulus(4'h0, 32'h00);
    applyStimulus(4'h0, 32'h55);
    applyStimulus(4'h0, 32'hAA);
    n = 0;
    while (o_Tx_1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checkOutput("pre_reset_line", 32'(o_Tx_1), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_tx", 32'(o_Tx_1), 32'd1);
    checkOutput("async_rdata", o_ReadData_32, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkReg("post_reset_status", 4'h4, 32'h4);
    checkReg("post_reset_baud", 4'h8, 32'd868);
    capQ.delete();
    capOn = 1'b1;
    repeat (60) @(negedge clk);
    capOn = 1'b0;
    zeros = 0;
    foreach (capQ[i]) if (capQ[i].tx !== 1'b1) zeros++;
    checkOutput("no_frames_after_reset", 32'(zeros), 32'd0);
    readReg(4'h0, dummy);
    checkOutput("txdata_reads_zero", dummy, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
